// File: rtl/spike_streamer.sv
// Spike streamer: reads R spike bundles from a synchronous-read spike memory in
// address order and forwards them to the synapse array with a valid qualifier.
module spike_streamer #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 24,
  parameter int MAX_ROWS   = 432
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_run,
  input  logic [ADDR_WIDTH-1:0] i_num_rows,
  input  logic                  i_hold,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_ce,
  input  logic [DATA_WIDTH-1:0] i_q,
  output logic [DATA_WIDTH-1:0] o_spike_bundle,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_row_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_R = ADDR_WIDTH'(MAX_ROWS);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] rows;
  logic [ADDR_WIDTH-1:0] next_idx;
  logic [ADDR_WIDTH-1:0] req_rows;
  logic                  ce_d;

  assign req_rows = (i_num_rows > MAX_R) ? MAX_R : i_num_rows;

  // Read-issue FSM; index 0 is issued on the same edge that accepts i_run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rows      <= '0;
      next_idx  <= '0;
      o_addr    <= '0;
      o_ce      <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_row_cnt <= '0;
    end else begin
      o_done <= 1'b0;
      if (state == IDLE && i_run) begin
        o_row_cnt <= '0;
      end else if (ce_d) begin
        o_row_cnt <= o_row_cnt + ONE;
      end
      case (state)
        IDLE: begin
          o_ce <= 1'b0;
          if (i_run) begin
            rows   <= req_rows;
            o_busy <= 1'b1;
            if (req_rows == '0) begin
              state <= DONE;
            end else begin
              o_addr <= '0;
              if (!i_hold) begin
                o_ce     <= 1'b1;
                next_idx <= ONE;
                state    <= (req_rows == ONE) ? DRAIN : ISSUE;
              end else begin
                next_idx <= '0;
                state    <= ISSUE;
              end
            end
          end
        end
        ISSUE: begin
          if (!i_hold) begin
            o_ce     <= 1'b1;
            o_addr   <= next_idx;
            next_idx <= next_idx + ONE;
            if (next_idx == rows - ONE) state <= DRAIN;
          end else begin
            o_ce <= 1'b0;
          end
        end
        DRAIN: begin
          o_ce <= 1'b0;
          // Last read has left the memory and is being registered this edge.
          if (!o_ce && ce_d) state <= DONE;
        end
        DONE: begin
          o_ce   <= 1'b0;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ce_d           <= 1'b0;
      o_valid        <= 1'b0;
      o_spike_bundle <= '0;
    end else begin
      ce_d    <= o_ce;
      o_valid <= ce_d;
      if (ce_d) o_spike_bundle <= i_q;
    end
  end

endmodule

// File: tb/tb_spike_streamer.sv
// Directed bench for spike_streamer with a behavioural spike memory whose row k
// holds k*0x010101 (24-bit masked).
module tb_spike_streamer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_run;
  logic [8:0]  i_num_rows;
  logic        i_hold;
  logic [8:0]  o_addr;
  logic        o_ce;
  logic [23:0] i_q;
  logic [23:0] o_spike_bundle;
  logic        o_valid;
  logic        o_busy;
  logic        o_done;
  logic [8:0]  o_row_cnt;

  int checks = 0;
  int passes = 0;

  logic [23:0] bundles[$];
  int first_cyc, last_cyc, cyc;
  int done_cnt, ce_cnt, max_addr, done_row_cnt;

  spike_streamer dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_rows(i_num_rows),
    .i_hold(i_hold), .o_addr(o_addr), .o_ce(o_ce), .i_q(i_q),
    .o_spike_bundle(o_spike_bundle), .o_valid(o_valid), .o_busy(o_busy),
    .o_done(o_done), .o_row_cnt(o_row_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rowVal(input int k);
    logic [31:0] v;
    v = k * 32'h0001_0101;
    return v[23:0];
  endfunction

  always @(posedge clk) begin
    if (o_ce) i_q <= rowVal(int'(o_addr));
  end

  // Monitor samples just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (o_valid) begin
      if (bundles.size() == 0) first_cyc = cyc;
      last_cyc = cyc;
      bundles.push_back(o_spike_bundle);
    end
    if (o_ce) begin
      ce_cnt = ce_cnt + 1;
      if (int'(o_addr) > max_addr) max_addr = int'(o_addr);
    end
    if (o_done) begin
      done_cnt = done_cnt + 1;
      done_row_cnt = int'(o_row_cnt);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual === expected) passes = passes + 1;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  task automatic clearMon();
    bundles.delete();
    first_cyc = 0; last_cyc = 0;
    done_cnt = 0; ce_cnt = 0; max_addr = 0; done_row_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [8:0] rows);
    @(negedge clk);
    i_run = 1'b1;
    i_num_rows = rows;
    @(negedge clk);
    i_run = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, (done_cnt != 0), 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic checkOrder(input string tag, input int n);
    int errs = 0;
    for (int i = 0; i < n && i < bundles.size(); i++)
      if (bundles[i] !== rowVal(i)) errs++;
    checkOutput(tag, errs, 0);
  endtask

  initial begin
    cyc = 0;
    clearMon();
    i_q = '0;
    reset_n = 1'b0; i_run = 1'b0; i_num_rows = '0; i_hold = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_outputs", {o_ce, o_valid, o_busy, o_done}, 4'b0000);
    checkOutput("rst_addr", o_addr, 0);
    checkOutput("rst_cnt", o_row_cnt, 0);
    checkOutput("rst_bundle", o_spike_bundle, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Cycle-exact latency with R=3
    clearMon();
    i_run = 1'b1; i_num_rows = 9'd3;
    @(negedge clk); i_run = 1'b0;
    checkOutput("lat_n_ce_busy", {o_ce, o_busy, o_valid}, 3'b110);
    checkOutput("lat_n_addr", o_addr, 0);
    @(negedge clk);
    checkOutput("lat_n1_addr", o_addr, 1);
    checkOutput("lat_n1_valid", o_valid, 0);
    @(negedge clk);
    checkOutput("lat_n2_valid", o_valid, 1);
    checkOutput("lat_n2_bundle", o_spike_bundle, 24'h000000);
    checkOutput("lat_n2_addr", o_addr, 2);
    @(negedge clk);
    checkOutput("lat_n3_bundle", o_spike_bundle, 24'h010101);
    checkOutput("lat_n3_ce", o_ce, 0);
    @(negedge clk);
    checkOutput("lat_n4_bundle", o_spike_bundle, 24'h020202);
    checkOutput("lat_n4_cnt", o_row_cnt, 3);
    checkOutput("lat_n4_done", o_done, 0);
    @(negedge clk);
    checkOutput("lat_n5_done_busy_valid", {o_done, o_busy, o_valid}, 3'b100);
    checkOutput("lat_n5_cnt", o_row_cnt, 3);
    @(negedge clk);
    checkOutput("lat_n6_done", o_done, 0);

    // Full 432-row stream
    clearMon();
    applyStimulus(9'd432);
    waitDone("full_done", 1000);
    checkOutput("full_count", bundles.size(), 432);
    checkOrder("full_order", 432);
    checkOutput("full_contig", last_cyc - first_cyc + 1, 432);
    checkOutput("full_done_once", done_cnt, 1);
    checkOutput("full_rowcnt", done_row_cnt, 432);
    checkOutput("full_maxaddr", max_addr, 431);

    // Hold for three issue slots after the second issue
    clearMon();
    applyStimulus(9'd5);
    @(negedge clk); i_hold = 1'b1;
    repeat (3) @(negedge clk);
    i_hold = 1'b0;
    waitDone("hold_done", 100);
    checkOutput("hold_count", bundles.size(), 5);
    checkOrder("hold_order", 5);
    checkOutput("hold_gap", (last_cyc - first_cyc + 1) - 5, 3);
    checkOutput("hold_ce_cnt", ce_cnt, 5);

    // Zero rows
    clearMon();
    @(negedge clk); i_run = 1'b1; i_num_rows = 9'd0;
    @(negedge clk); i_run = 1'b0;
    checkOutput("zero_n_done", o_done, 0);
    @(negedge clk);
    checkOutput("zero_n1_done", o_done, 1);
    repeat (4) @(negedge clk);
    checkOutput("zero_no_ce", ce_cnt, 0);
    checkOutput("zero_no_valid", bundles.size(), 0);
    checkOutput("zero_done_once", done_cnt, 1);

    // Second i_run mid-stream is ignored
    clearMon();
    applyStimulus(9'd10);
    repeat (3) @(negedge clk);
    applyStimulus(9'd3);
    waitDone("rerun_done", 100);
    checkOutput("rerun_count", bundles.size(), 10);
    checkOrder("rerun_order", 10);
    checkOutput("rerun_done_once", done_cnt, 1);

    // Reset after 100 bundles
    clearMon();
    applyStimulus(9'd200);
    begin
      int n = 0;
      while (bundles.size() < 100 && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("mid_reached_100", bundles.size(), 100);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("mid_rst_flags", {o_ce, o_valid, o_busy, o_done}, 4'b0000);
    checkOutput("mid_rst_regs", {o_addr, o_row_cnt}, 0);
    checkOutput("mid_rst_bundle", o_spike_bundle, 0);
    repeat (6) @(negedge clk);
    checkOutput("mid_no_done", done_cnt, 0);
    checkOutput("mid_no_more", bundles.size(), 100);
    clearMon();
    applyStimulus(9'd4);
    waitDone("post_done", 100);
    checkOutput("post_count", bundles.size(), 4);
    checkOrder("post_order", 4);
    checkOutput("post_maxaddr", max_addr, 3);

    // Oversized request is clamped
    clearMon();
    applyStimulus(9'd511);
    waitDone("clamp_done", 1000);
    checkOutput("clamp_count", bundles.size(), 432);
    checkOutput("clamp_maxaddr", max_addr, 431);
    checkOutput("clamp_rowcnt", done_row_cnt, 432);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spike_streamer.md
SPIKE_STREAMER -- requirements
Module: spike_streamer

Interface
REQ-001 Parameter: ADDR_WIDTH, 9, spike-memory address width.
REQ-002 Parameter: DATA_WIDTH, 24, spike bundle width (6 groups x 4 spikes).
REQ-003 Parameter: MAX_ROWS, 432, largest legal row count.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 i_run  input  1  start pulse; sampled only in IDLE.
REQ-007 i_num_rows  input  ADDR_WIDTH  rows to stream; latched on accepted i_run.
REQ-008 i_hold  input  1  stall request; while high no new memory read is issued.
REQ-009 o_addr  output  ADDR_WIDTH  spike-memory read address.
REQ-010 o_ce  output  1  spike-memory chip enable (read only; no write port).
REQ-011 i_q  input  DATA_WIDTH  spike-memory read data, valid one cycle after the edge sampling o_ce.
REQ-012 o_spike_bundle  output  DATA_WIDTH  spike bundle to synapse i_spike_bundle.
REQ-013 o_valid  output  1  bundle qualifier to synapse i_valid.
REQ-014 o_busy  output  1  high from accepted i_run until o_done.
REQ-015 o_done  output  1  one-cycle completion pulse.
REQ-016 o_row_cnt  output  ADDR_WIDTH  count of bundles emitted in the current run.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on i_run with i_num_rows>0; IDLE->DONE on i_run with i_num_rows==0.
REQ-018 ISSUE: each edge with i_hold low registers o_ce=1 and o_addr=next index (0,1,...); edge with i_hold high registers o_ce=0, o_addr held.
REQ-019 ISSUE->DRAIN on the edge that issues index i_num_rows-1; DRAIN registers o_ce=0.
REQ-020 Output stage: on every edge, o_valid <= o_ce delayed one cycle, o_spike_bundle <= i_q when that delayed o_ce is 1, else hold previous value.
REQ-021 Latency: i_run sampled at edge N, no hold -> o_ce/o_addr=0 after edge N, first o_valid after edge N+2, last o_valid after edge N+R+1 (R = i_num_rows).
REQ-022 Bundles pass through unmodified, bit order preserved (bit 4j+k = group j, spike k).
REQ-023 Hold affects only issue: reads already issued always reach the output; o_valid drops exactly two cycles after the first held issue slot and resumes two cycles after release.
REQ-024 DRAIN->DONE when the final in-flight bundle has been registered (o_valid of last row high); DONE lasts one cycle with o_done=1, o_busy=0, then IDLE.
REQ-025 o_row_cnt clears on accepted i_run, increments on each cycle o_valid is registered high; equals R during DONE.
REQ-026 i_run while not IDLE is ignored; i_num_rows changes after acceptance have no effect.
REQ-027 i_num_rows > MAX_ROWS is clamped to MAX_ROWS.
REQ-028 i_num_rows==0: no o_ce, no o_valid; o_done pulse after edge N+1.
REQ-029 o_addr never exceeds R-1; no wrap-around within a run.

Reset
REQ-030 reset_n low at an edge: state IDLE, o_addr=0, o_ce=0, o_spike_bundle=0, o_valid=0, o_busy=0, o_done=0, o_row_cnt=0.
REQ-031 Reset mid-run aborts immediately; in-flight read data is discarded, no o_done is produced.

Verification
REQ-032 Memory preloaded row k = k*0x010101 masked, R=432, no hold -> 432 consecutive o_valid cycles with bundles in address order, o_done once, o_row_cnt=432; synapse DUT then produces o_done.
REQ-033 R=5, i_hold high for 3 cycles starting after 2nd issue -> o_valid gap of exactly 3 cycles, 5 bundles total, order intact.
REQ-034 i_num_rows=0 -> o_done one cycle after acceptance edge + 1, o_ce and o_valid never asserted.
REQ-035 Second i_run pulse mid-stream with different i_num_rows -> ignored; original R bundles emitted, single o_done.
REQ-036 reset_n low for one cycle after 100 bundles -> all outputs 0 next cycle, no o_done; fresh i_run then streams from address 0.
REQ-037 i_num_rows=511 -> exactly 432 bundles, max o_addr 431.
